// File: rtl/idli_pkg.sv
// Shared SQI definitions: command opcodes, nibble type and the memory-slave FSM states.
package idli_pkg;

   typedef logic [3:0] sqi_data_t;

   localparam logic [7:0] SQI_CMD_RD = 8'h03;
   localparam logic [7:0] SQI_CMD_WR = 8'h02;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DUMMY,
      RD,
      WR,
      IGNORE
   } sqi_mem_state_t;

endpackage

// File: rtl/idli_sqi_mem_ram_m.sv
// DEPTH x 8 single-port RAM, synchronous read with one gck latency; rdata holds between reads.
module idli_sqi_mem_ram_m #(
   parameter int DEPTH = 65536,
   parameter int AW    = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end else if (re) begin
         rdata_q <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/idli_sqi_mem_m.sv
// Quad-SPI SRAM slave: oversamples sck on the system clock, decodes READ/WRITE frames
// and serves them from a local RAM that can also be preloaded over a backdoor port.
module idli_sqi_mem_m
   import idli_pkg::*;
#(
   parameter int DEPTH = 65536,
   parameter int DUMMY = 2
) (
   input  logic        i_mem_gck,
   input  logic        i_mem_rst,
   input  logic        i_mem_sck,
   input  logic        i_mem_cs,
   input  logic [3:0]  i_mem_sio,
   output logic [3:0]  o_mem_sio,
   output logic        o_mem_sio_oe,
   input  logic        i_mem_ld_vld,
   input  logic [15:0] i_mem_ld_addr,
   input  logic [7:0]  i_mem_ld_data
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = $clog2(DUMMY + 1);

   sqi_mem_state_t state_q, state_d;
   logic           sck_q;
   logic           cs_q;
   logic [1:0]     nib_ctr_q, nib_ctr_d;
   logic [DW-1:0]  dmy_ctr_q, dmy_ctr_d;
   logic [7:0]     cmd_q, cmd_d;
   logic [15:0]    addr_q, addr_d;
   sqi_data_t      wbuf_q, wbuf_d;
   sqi_data_t      sio_q, sio_d;
   logic           oe_q, oe_d;

   logic           rise, fall, cs_fall;
   logic [7:0]     opcode;
   logic           ram_we, ram_re;
   logic [AW-1:0]  ram_addr;
   logic [7:0]     ram_wdata, ram_rdata;

   assign rise    = i_mem_sck & ~sck_q;
   assign fall    = ~i_mem_sck & sck_q;
   // cs_q resets low so a frame cut by reset needs cs high-then-low before decoding resumes
   assign cs_fall = ~i_mem_cs & cs_q;
   assign opcode  = {cmd_q[3:0], i_mem_sio};

   always_ff @(posedge i_mem_gck) begin
      if (i_mem_rst) begin
         state_q   <= IDLE;
         sck_q     <= 1'b0;
         cs_q      <= 1'b0;
         nib_ctr_q <= '0;
         dmy_ctr_q <= '0;
         cmd_q     <= '0;
         addr_q    <= '0;
         wbuf_q    <= '0;
         sio_q     <= '0;
         oe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         sck_q     <= i_mem_sck;
         cs_q      <= i_mem_cs;
         nib_ctr_q <= nib_ctr_d;
         dmy_ctr_q <= dmy_ctr_d;
         cmd_q     <= cmd_d;
         addr_q    <= addr_d;
         wbuf_q    <= wbuf_d;
         sio_q     <= sio_d;
         oe_q      <= oe_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (i_mem_cs) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (cs_fall) state_d = CMD;
            CMD: begin
               if (rise && nib_ctr_q[0]) begin
                  state_d = (opcode == SQI_CMD_RD || opcode == SQI_CMD_WR) ? ADDR : IGNORE;
               end
            end
            ADDR: begin
               if (rise && nib_ctr_q == 2'd3) begin
                  state_d = (cmd_q == SQI_CMD_RD) ? idli_pkg::DUMMY : WR;
               end
            end
            idli_pkg::DUMMY: if (rise && dmy_ctr_q == DW'(DUMMY - 1)) state_d = RD;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      nib_ctr_d = nib_ctr_q;
      dmy_ctr_d = dmy_ctr_q;
      cmd_d     = cmd_q;
      addr_d    = addr_q;
      wbuf_d    = wbuf_q;
      sio_d     = sio_q;
      oe_d      = oe_q;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_addr  = addr_q[AW-1:0];
      ram_wdata = {wbuf_q, i_mem_sio};
      if (i_mem_cs) begin
         nib_ctr_d = '0;
         dmy_ctr_d = '0;
         oe_d      = 1'b0;
         sio_d     = '0;
         if (i_mem_ld_vld && state_q == IDLE) begin
            ram_we    = 1'b1;
            ram_addr  = i_mem_ld_addr[AW-1:0];
            ram_wdata = i_mem_ld_data;
         end
      end else begin
         case (state_q)
            CMD: begin
               if (rise) begin
                  cmd_d     = opcode;
                  nib_ctr_d = nib_ctr_q[0] ? 2'd0 : 2'd1;
               end
            end
            ADDR: begin
               if (rise) begin
                  addr_d    = {addr_q[11:0], i_mem_sio};
                  nib_ctr_d = nib_ctr_q + 2'd1;
                  if (nib_ctr_q == 2'd3 && cmd_q == SQI_CMD_RD) begin
                     ram_re   = 1'b1;
                     ram_addr = addr_d[AW-1:0];
                  end
               end
            end
            idli_pkg::DUMMY: begin
               if (rise) dmy_ctr_d = (dmy_ctr_q == DW'(DUMMY - 1)) ? '0 : dmy_ctr_q + DW'(1);
            end
            RD: begin
               // RAM output register doubles as the prefetch register; next byte is read
               // as soon as the lo nibble leaves, well ahead of the following fall
               if (fall) begin
                  oe_d  = 1'b1;
                  sio_d = nib_ctr_q[0] ? ram_rdata[3:0] : ram_rdata[7:4];
                  if (nib_ctr_q[0]) begin
                     addr_d    = addr_q + 16'd1;
                     ram_re    = 1'b1;
                     ram_addr  = addr_d[AW-1:0];
                     nib_ctr_d = 2'd0;
                  end else begin
                     nib_ctr_d = 2'd1;
                  end
               end
            end
            WR: begin
               if (rise) begin
                  if (!nib_ctr_q[0]) begin
                     wbuf_d    = i_mem_sio;
                     nib_ctr_d = 2'd1;
                  end else begin
                     ram_we    = 1'b1;
                     addr_d    = addr_q + 16'd1;
                     nib_ctr_d = 2'd0;
                  end
               end
            end
            default: begin
               nib_ctr_d = nib_ctr_q;
            end
         endcase
      end
   end

   always_comb begin
      o_mem_sio    = sio_q;
      o_mem_sio_oe = oe_q;
   end

   idli_sqi_mem_ram_m #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (i_mem_gck),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule
